// File: rtl/lsu_mem_master_if.sv
// LSU core-side request/response and memory-bus signals
// master = LSU side, slave = core/memory side
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_funct3,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_funct3,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store bus master with timeout abort.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned half/word.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [10:0] cnt_inc;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cap;
  logic        is_b, is_h, is_s;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] ld;
  logic [3:0]  strb_base;

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic misal(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic b, h;
    b = (f3 == 3'b000) || (f3 == 3'b100);
    h = (f3 == 3'b001) || (f3 == 3'b101);
    if (b) return 1'b0;
    if (h) return a[0];
    return a != 2'b00;
  endfunction
`endif

  assign is_b = (f3_q == 3'b000) || (f3_q == 3'b100);
  assign is_h = (f3_q == 3'b001) || (f3_q == 3'b101);
  assign is_s = ~f3_q[2];
  assign sh   = {addr_q[1:0], 3'b000};
  assign lane = bus.mem_rdata >> sh;
  assign cnt_inc = {1'b0, cnt_q} + 11'd1;

  // Lane select and sign/zero extension of the read word
  always_comb begin
    ld = lane;
    unique case (1'b1)
      is_b:    ld = {{24{is_s & lane[7]}}, lane[7:0]};
      is_h:    ld = {{16{is_s & lane[15]}}, lane[15:0]};
      default: ld = lane;
    endcase
  end

  // Byte-enable pattern before lane shifting
  always_comb begin
    strb_base = 4'b1111;
    unique case (1'b1)
      is_b:    strb_base = 4'b0001;
      is_h:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // Next-state, timeout counter and result latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cap     = 1'b1;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
          if (misal(bus.req_funct3, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[9:0];
        if (bus.mem_rvalid) begin
          rdata_d = wen_q ? 32'd0 : ld;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_inc == 11'(TIMEOUT_CYC)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the request fields on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (cap) begin
      wen_q   <= bus.req_wen;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      f3_q    <= bus.req_funct3;
    end
  end

  assign bus.req_ready  = rst_n & (state_q == S_IDLE);
  assign bus.resp_valid = state_q == S_RESP;
  assign bus.resp_err   = (state_q == S_RESP) & err_q;
  assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign bus.mem_valid  = state_q == S_REQ;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = wdata_q << sh;
  assign bus.mem_wstrb  = wen_q ? (strb_base << addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a transaction-level model
// Honours LSU_MISALIGN_CHECK_EN when the design is built with it
module tb_lsu_mem_master;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_master_if bus();

  lsu_mem_master #(.TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input int off);
    return (off % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit wen, input int off,
                                        input logic [2:0] f3);
    logic [3:0] s;
    s = '0;
    if (wen)
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + size_of(f3)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd,
                                          input int off);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off) o[8*i +: 8] = wd[8*(i-off) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd,
                                         input int off,
                                         input logic [2:0] f3);
    longint v;
    int sz;
    sz = size_of(f3);
    v = 0;
    for (int k = 0; k < sz; k++)
      if (off + k < 4) v += longint'(rd[8*(off+k) +: 8]) << (8*k);
    if ((f3 == 3'd0 || f3 == 3'd1) &&
        v >= (longint'(1) << (8*sz-1)))
      v -= (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  task automatic txn(input bit wen, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] f3,
                     input int d_r, input int d_v,
                     input logic [31:0] rd);
    int off, lat, mv, w, exp_lat, wc;
    bit acc, got, xmis, xerr;
    logic mv_s, mr_s;
    logic [31:0] xrd;
    off = int'(addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
    xmis = is_mis(f3, off);
`else
    xmis = 1'b0;
`endif
    wc = (d_v + 1 < TO) ? d_v + 1 : TO;
    xerr = xmis || (d_v >= TO);
    exp_lat = xmis ? 1 : 1 + (d_r + 1) + wc;
    xrd = (xerr || wen) ? 32'd0 : m_load(rd, off, f3);
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    mv = 0; w = 0; acc = 1'b0; got = 1'b0;
    while (!got && lat < 200) begin
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        bus.mem_ready  = 1'($urandom);
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata  = $urandom;
        if (bus.mem_valid) begin
          chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
          chk("mem_wen", 32'(bus.mem_wen), 32'(wen));
          chk("mem_wstrb", 32'(bus.mem_wstrb),
              32'(m_strb(wen, off, f3)));
          if (wen) chk("mem_wdata", bus.mem_wdata, m_wdata(wd, off));
          bus.mem_ready = (mv >= d_r);
          mv++;
        end
        if (acc) begin
          bus.mem_rvalid = (w >= d_v);
          if (bus.mem_rvalid) bus.mem_rdata = rd;
          w++;
        end
        mv_s = bus.mem_valid;
        mr_s = bus.mem_ready;
        @(posedge clk);
        lat++;
        if (mv_s && mr_s) acc = 1'b1;
        @(negedge clk);
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", lat, exp_lat);
    chk("resp_err", 32'(bus.resp_err), 32'(xerr));
    chk("resp_rdata", bus.resp_rdata, xrd);
    chk("mem_valid_cycles", mv, xmis ? 0 : d_r + 1);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic rst_mid();
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b0;
    bus.req_addr   = 32'h8000_0100;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_mid_mem_valid", 32'(bus.mem_valid), 32'd1);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("rst_mid_in_wait", 32'(bus.mem_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready_low", 32'(bus.req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
    end
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h8000_0003, 32'd0, 3'b000, 0, 0, 32'h80FF_1234);
    txn(1'b1, 32'h8000_0002, 32'h0000_ABCD, 3'b001, 0, 0, $urandom);
    txn(1'b0, 32'h8000_0010, 32'd0, 3'b010, 5, 0, 32'hDEAD_BEEF);
    txn(1'b0, 32'h8000_0020, 32'd0, 3'b010, 0, 100, $urandom);
    txn(1'b0, 32'h8000_0024, 32'd0, 3'b101, 1, TO - 1, 32'h9876_5432);
    txn(1'b0, 32'h8000_0001, 32'd0, 3'b010, 0, 0, 32'h1122_3344);
    txn(1'b1, 32'h8000_0003, 32'hCAFE_F00D, 3'b001, 2, 1, $urandom);
    txn(1'b0, 32'h8000_0006, 32'd0, 3'b111, 0, 0, 32'hA5A5_5A5A);
    rst_mid();
    for (int i = 0; i < 300; i++)
      txn(1'($urandom), $urandom, $urandom, 3'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 2)),
          $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
